// File: rtl/switch_egress_arb_pkg.sv
// pkg_switch: types shared across the switch egress path.
package pkg_switch;
  localparam int NUM_PORTS = 4;
  typedef logic [1:0] port_id_t;
  typedef enum logic {EGR_IDLE, EGR_XFER} egr_state_e;
endpackage

// File: rtl/switch_egress_arb_rr_arb4.sv
// rr_arb4: combinational 4-way priority pick starting the search at ptr.
module rr_arb4
  import pkg_switch::*;
(
  input  logic [3:0] req,
  input  port_id_t   ptr,
  output port_id_t   win,
  output logic       any
);
  // Walk the search order backwards so the earliest candidate assigns last.
  always_comb begin
    win = ptr;
    for (int k = 3; k >= 0; k--)
      if (req[ptr + port_id_t'(k)]) win = ptr + port_id_t'(k);
  end
  assign any = |req;
endmodule

// File: rtl/switch_egress_arb.sv
// switch_egress_arb: packet-granular round-robin egress arbiter feeding a
// single suspendable output register stage.
module switch_egress_arb
  import pkg_switch::*;
#(
  parameter int DW   = 8,
  parameter int CNTW = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              in_valid,
  input  logic [3:0]              in_sop,
  input  logic [3:0]              in_eop,
  input  logic [NUM_PORTS*DW-1:0] in_data,
  output logic [3:0]              in_ready,
  input  logic                    op_suspend,
  output logic                    out_valid,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic [DW-1:0]           out_data,
  output logic [1:0]              out_src,
  output logic [CNTW-1:0]         pkt_cnt,
  output logic                    proto_err
);
  egr_state_e state, state_nx;
  port_id_t rr_ptr, gnt, win;
  logic any, first, ld, acc, sop_g, eop_g;
  rr_arb4 u_arb (.req(in_valid & in_sop), .ptr(rr_ptr), .win(win), .any(any));
  assign ld       = !out_valid || !op_suspend;
  assign in_ready = (state == EGR_XFER && ld) ? 4'b0001 << gnt : 4'b0000;
  assign acc      = in_valid[gnt] && in_ready[gnt];
  assign sop_g    = in_sop[gnt];
  assign eop_g    = in_eop[gnt];
  always_comb begin
    state_nx = state;
    state_nx = (state == EGR_IDLE) ? (any ? EGR_XFER : EGR_IDLE)
                                   : ((acc && eop_g) ? EGR_IDLE : EGR_XFER);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= EGR_IDLE;
    else state <= state_nx;
  // first marks the grant's opening beat; sop must coincide with it exactly.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rr_ptr    <= '0;
      gnt       <= '0;
      first     <= 1'b0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      pkt_cnt   <= '0;
      proto_err <= 1'b0;
    end else begin
      if (state == EGR_IDLE && any) begin
        gnt    <= win;
        rr_ptr <= win + port_id_t'(1);
        first  <= 1'b1;
      end
      if (acc) first <= 1'b0;
      if (ld) out_valid <= acc;
      if (acc) begin
        out_data <= in_data[gnt*DW +: DW];
        out_sop  <= sop_g;
        out_eop  <= eop_g;
        out_src  <= gnt;
      end
      if (acc && eop_g) pkt_cnt <= pkt_cnt + CNTW'(1);
      proto_err <= acc && (first ^ sop_g);
    end
endmodule

// File: doc/switch_egress_arb.md
# switch_egress_arb

Egress stage of the 4-port switch. It sits between the four ingress-side packet sources routed to one output and the output port's `design_if` transmit side. It arbitrates at packet granularity with round-robin fairness and holds a grant until end-of-packet. It forwards the winning packet through one registered output stage that honours the port's suspend input. The switch instantiates one per output port (four total).

## Interface
Parameters:
- `DW`, 8: data width of one beat.
- `CNTW`, 16: width of the forwarded-packet counter.

Ports:
- `clk`  in  1  switch clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  4  per-source beat valid.
- `in_sop`  in  4  per-source start-of-packet flag, qualified by `in_valid[i]`.
- `in_eop`  in  4  per-source end-of-packet flag, qualified by `in_valid[i]`.
- `in_data`  in  4×DW  per-source beat data.
- `in_ready`  out  4  per-source beat accepted this cycle when `in_valid[i] && in_ready[i]`.
- `op_suspend`  in  1  downstream stall; output holds while high.
- `out_valid`  out  1  output beat valid.
- `out_sop`  out  1  output start-of-packet.
- `out_eop`  out  1  output end-of-packet.
- `out_data`  out  DW  output beat data.
- `out_src`  out  2  source index of the current output beat.
- `pkt_cnt`  out  CNTW  count of packets forwarded (eop beats accepted), wraps.
- `proto_err`  out  1  one-cycle pulse on a framing violation.

## Operation
- FSM has two states:
  - IDLE: picks a source. Candidates are sources with `in_valid[i] && in_sop[i]`.
  - XFER: forwards beats from the granted source `gnt`.
- Round-robin pointer `rr_ptr` (2 bits):
  - Search order is `rr_ptr, rr_ptr+1, …` mod 4. The first candidate wins.
  - On grant, `gnt` takes the winner and `rr_ptr` takes winner+1 mod 4.
- IDLE→XFER: taken when any candidate exists. No beat is accepted in the IDLE cycle.
- Output stage load enable: `ld = !out_valid || !op_suspend`.
- In XFER, `in_ready[gnt] = ld`. All other `in_ready` bits are 0. In IDLE, all `in_ready` bits are 0.
- Accepted beat: registers `in_data[gnt]`, `in_sop[gnt]`, `in_eop[gnt]` and `gnt` into the out_* registers, and sets `out_valid`.
- If `ld` is high with no accepted beat, `out_valid` clears.
- An accepted beat with eop returns the FSM to IDLE and increments `pkt_cnt`.
- A single-beat packet (sop and eop together) is legal.
- Framing violations, each a `proto_err` pulse:
  - Accepted beat with sop that is not the first beat of the grant. The beat is still forwarded.
  - First accepted beat of a grant without sop. This cannot occur through IDLE selection; checked defensively.
- Sources without a grant are unaffected. Their valid/data must be held stable by the source.

## Timing
- Reset values:
  - FSM IDLE, `rr_ptr`=0, `gnt`=0.
  - `in_ready`=0, `out_valid`=0, `out_sop`=0, `out_eop`=0, `out_data`=0, `out_src`=0.
  - `pkt_cnt`=0, `proto_err`=0.
- Arbitration latency: sop visible in cycle N (IDLE) → grant in N+1 → first beat accepted at the end of N+1 → `out_valid` in N+2.
- Throughput: one beat per cycle while `op_suspend`=0.
- Idle bubble between packets: one IDLE cycle after each eop.
- Suspend:
  - While `op_suspend`=1 and `out_valid`=1, the out_* registers hold and `in_ready`=0 in that cycle.
  - Deasserting `op_suspend` releases the held beat in the same cycle.
- Suspend when `out_valid`=0: the stage still accepts one beat, then holds it.
- Reset mid-packet: everything returns to reset values asynchronously. The partial packet is abandoned and the source must restart with sop.
- `pkt_cnt` wraps from 2^CNTW−1 to 0.
- All four sources requesting simultaneously: served in rr order, with exactly one packet each before any repeats.

## Structure
- Shared package `pkg_switch` holds:
  - `port_id_t` (logic [1:0]) and `NUM_PORTS`=4.
  - The FSM state enum `egr_state_e` {EGR_IDLE, EGR_XFER}.
- Sub-module `rr_arb4`: combinational pointer-rotated priority pick over 4 requests, outputs `win` and `any`. Pointer storage stays in the parent.

## Test plan
- Reset, then a 3-beat packet (0x11, 0x22, 0x33) on source 2 only → `out_valid` two cycles after sop, `out_src`=2, sop on 0x11, eop on 0x33, `pkt_cnt`=1.
- All sources present a 2-beat packet at once after reset → output order 0, 1, 2, 3; then resubmit from 0 and 3 only → order 0, 3; `pkt_cnt`=6.
- 4-beat packet from source 1 with `op_suspend` high for 3 cycles after beat 2 → beat 2 held 3 cycles, no duplicate and no lost beats, `in_ready[1]` low throughout the suspend.
- Single-beat packets from 0 and 1 back-to-back → each forwarded with sop=eop=1, one IDLE cycle between them.
- Source 3 raises sop on its 2nd beat mid-packet → `proto_err` one-cycle pulse, beat still forwarded, grant kept until eop.
- Assert `reset` during beat 2 of a 5-beat packet → all outputs at reset values immediately; the source restarts and the full packet forwards cleanly, `pkt_cnt`=1.
